// File: rtl/rf_wb_pkg.sv
// Shared types and default sizes for the register-file write-back front end.
package rf_wb_pkg;

    localparam int RF_WB_DATA_WIDTH  = 32;
    localparam int RF_WB_REG_NUM     = 32;
    localparam int RF_WB_REG_NUM_BIT = 5;
    localparam int RF_WB_STARVE_MAX  = 4;

    // Source selected by the write-port arbiter in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_EXU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_writeback_scoreboard.sv
// Busy-bit scoreboard for pending register writes, plus hazard queries that
// also cover the write currently in flight on the register file port.
module rf_scoreboard
    import rf_wb_pkg::*;
#(
    parameter int REG_NUM     = RF_WB_REG_NUM,
    parameter int REG_NUM_BIT = RF_WB_REG_NUM_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set,
    input  logic [REG_NUM_BIT-1:0] set_rd,
    input  logic                   clr,
    input  logic [REG_NUM_BIT-1:0] clr_rd,
    input  logic                   wb_wen,
    input  logic [REG_NUM_BIT-1:0] wb_waddr,
    input  logic [REG_NUM_BIT-1:0] rs1_q,
    input  logic [REG_NUM_BIT-1:0] rs2_q,
    output logic                   rs1_busy,
    output logic                   rs2_busy
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    // Clear for the retiring write first, then set: a same-register set wins
    // because it belongs to the younger producer.
    always_comb begin
        busy_d = busy_q;
        if (clr && (clr_rd != '0)) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set && (set_rd != '0)) begin
            busy_d[set_rd] = 1'b1;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Register 0 never reports busy; the in-flight term holds the hazard for
    // the cycle where the bit is already cleared but the write hasn't landed.
    assign rs1_busy = (rs1_q != '0) && (busy_q[rs1_q] || (wb_wen && (wb_waddr == rs1_q)));
    assign rs2_busy = (rs2_q != '0) && (busy_q[rs2_q] || (wb_wen && (wb_waddr == rs2_q)));

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-back front end: arbitrates EXU/LSU results onto a
// registered write port and tracks pending destinations for hazard checks.
// Optional performance counters are built when RF_WB_PERF_EN is defined.
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int DATA_WIDTH  = RF_WB_DATA_WIDTH,
    parameter int REG_NUM     = RF_WB_REG_NUM,
    parameter int REG_NUM_BIT = RF_WB_REG_NUM_BIT,
    parameter int STARVE_MAX  = RF_WB_STARVE_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exu_valid,
    output logic                   exu_ready,
    input  logic [REG_NUM_BIT-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0]  exu_data,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [REG_NUM_BIT-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]  lsu_data,
    input  logic                   sb_set,
    input  logic [REG_NUM_BIT-1:0] sb_set_rd,
    input  logic [REG_NUM_BIT-1:0] rs1_q,
    input  logic [REG_NUM_BIT-1:0] rs2_q,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   wen,
    output logic [REG_NUM_BIT-1:0] waddr,
    output logic [DATA_WIDTH-1:0]  wdata
`ifdef RF_WB_PERF_EN
    ,
    output logic [31:0]            perf_exu_cnt,
    output logic [31:0]            perf_lsu_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    wb_src_e                grant;
    logic                   xfer;
    logic [REG_NUM_BIT-1:0] xfer_rd;
    logic [DATA_WIDTH-1:0]  xfer_data;

    logic [CNT_W-1:0]       starve_q, starve_d;
    logic                   wen_q, wen_d;
    logic [REG_NUM_BIT-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

    // Arbiter: LSU has priority unless the EXU has lost STARVE_MAX times in a row.
    always_comb begin
        grant = WB_NONE;
        if (lsu_valid && exu_valid) begin
            grant = (starve_q == CNT_W'(STARVE_MAX)) ? WB_EXU : WB_LSU;
        end else if (lsu_valid) begin
            grant = WB_LSU;
        end else if (exu_valid) begin
            grant = WB_EXU;
        end
    end

    // While reset is high no source is told it was accepted; the flops
    // ignore the transfer path anyway.
    assign exu_ready = (grant == WB_EXU) && !rst;
    assign lsu_ready = (grant == WB_LSU) && !rst;

    assign xfer      = (grant != WB_NONE);
    assign xfer_rd   = (grant == WB_EXU) ? exu_rd   : lsu_rd;
    assign xfer_data = (grant == WB_EXU) ? exu_data : lsu_data;

    // Starvation counter and write-port next state.
    always_comb begin
        starve_d = starve_q;
        if (!exu_valid || (grant == WB_EXU)) begin
            starve_d = '0;
        end else if (starve_q != CNT_W'(STARVE_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        wen_d   = xfer && (xfer_rd != '0);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (wen_d) begin
            waddr_d = xfer_rd;
            wdata_d = xfer_data;
        end
    end

    // Write-port and starvation registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    rf_scoreboard #(
        .REG_NUM     (REG_NUM),
        .REG_NUM_BIT (REG_NUM_BIT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set      (sb_set),
        .set_rd   (sb_set_rd),
        .clr      (wen_d),
        .clr_rd   (xfer_rd),
        .wb_wen   (wen_q),
        .wb_waddr (waddr_q),
        .rs1_q    (rs1_q),
        .rs2_q    (rs2_q),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

`ifdef RF_WB_PERF_EN
    logic [31:0] perf_exu_q,   perf_exu_d;
    logic [31:0] perf_lsu_q,   perf_lsu_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Per-source accepted transfers and hazard-stall cycles, wrapping.
    always_comb begin
        perf_exu_d   = perf_exu_q;
        perf_lsu_d   = perf_lsu_q;
        perf_stall_d = perf_stall_q;
        if (grant == WB_EXU) begin
            perf_exu_d = perf_exu_q + 32'd1;
        end
        if (grant == WB_LSU) begin
            perf_lsu_d = perf_lsu_q + 32'd1;
        end
        if (rs1_busy || rs2_busy) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_exu_q   <= '0;
            perf_lsu_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_exu_q   <= perf_exu_d;
            perf_lsu_q   <= perf_lsu_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_exu_cnt   = perf_exu_q;
    assign perf_lsu_cnt   = perf_lsu_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback. Expected write-port values are queued
// when stimulus is driven and compared when the registered port updates.
module tb_rf_writeback;

    localparam int DW = 32;
    localparam int RB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          exu_valid, exu_ready;
    logic [RB-1:0] exu_rd;
    logic [DW-1:0] exu_data;
    logic          lsu_valid, lsu_ready;
    logic [RB-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          sb_set;
    logic [RB-1:0] sb_set_rd;
    logic [RB-1:0] rs1_q, rs2_q;
    logic          rs1_busy, rs2_busy;
    logic          wen;
    logic [RB-1:0] waddr;
    logic [DW-1:0] wdata;
`ifdef RF_WB_PERF_EN
    logic [31:0]   perf_exu_cnt, perf_lsu_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    rf_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .sb_set    (sb_set),
        .sb_set_rd (sb_set_rd),
        .rs1_q     (rs1_q),
        .rs2_q     (rs2_q),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata)
`ifdef RF_WB_PERF_EN
        ,
        .perf_exu_cnt   (perf_exu_cnt),
        .perf_lsu_cnt   (perf_lsu_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct packed {
        logic          wen;
        logic [RB-1:0] addr;
        logic [DW-1:0] data;
    } wb_exp_t;

    wb_exp_t       exp_q[$];
    wb_exp_t       e;
    int            checks = 0;
    int            errors = 0;
    int            exp_exu = 0;
    int            exp_lsu = 0;
    logic [RB-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the write-port state expected after the coming edge.
    task automatic push_write(input logic acc, input logic [RB-1:0] rd, input logic [DW-1:0] data);
        if (acc && rd != '0) begin
            last_addr = rd;
            last_data = data;
            exp_q.push_back('{1'b1, rd, data});
        end else begin
            exp_q.push_back('{1'b0, last_addr, last_data});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = '0;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = '0;
        sb_set = 1'b0; sb_set_rd = '0; rs1_q = '0; rs2_q = '0;
        tick(); tick();
        checks++;
        if ({wen, waddr, wdata} !== '0) begin
            errors++;
            $display("FAIL reset_port got wen=%0b waddr=%0d wdata=%h expected all zero", wen, waddr, wdata);
        end
        checks++;
        if (exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got exu=%0b lsu=%0b expected 0 0", exu_ready, lsu_ready);
        end
`ifdef RF_WB_PERF_EN
        checks++;
        if ({perf_exu_cnt, perf_lsu_cnt, perf_stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_perf got %0d %0d %0d expected 0 0 0", perf_exu_cnt, perf_lsu_cnt, perf_stall_cnt);
        end
`endif
        exu_valid = 1'b0; lsu_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_exu_only();
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h1234_5678;
        #1;
        checks++;
        if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL exu_only_ready got exu=%0b lsu=%0b expected 1 0", exu_ready, lsu_ready);
        end
        push_write(1'b1, exu_rd, exu_data); exp_exu++;
        tick();
        exu_valid = 1'b0;
        push_write(1'b0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) tick();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL exu_only_queue empty");
            end else begin
                e = exp_q.pop_front();
                if ({wen, waddr, wdata} !== e) begin
                    errors++;
                    $display("FAIL exu_only_port got wen=%0b waddr=%0d wdata=%h expected wen=%0b waddr=%0d wdata=%h",
                             wen, waddr, wdata, e.wen, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_starve();
        logic [11:0]   exu_v_mask = 12'b1111_1011_1111;
        logic [11:0]   exu_g_mask = 12'b1000_0001_0000;
        logic [RB-1:0] e_rd = 5'd4;
        logic [DW-1:0] e_data = 32'hE000_0000;
        logic          g;
        for (int i = 0; i < 12; i++) begin
            exu_valid = exu_v_mask[i]; exu_rd = e_rd; exu_data = e_data;
            lsu_valid = 1'b1; lsu_rd = RB'(16 + i); lsu_data = $urandom;
            #1;
            g = exu_g_mask[i];
            checks++;
            if (exu_ready !== g || lsu_ready !== !g) begin
                errors++;
                $display("FAIL starve_grant cycle=%0d got exu=%0b lsu=%0b expected exu=%0b lsu=%0b",
                         i, exu_ready, lsu_ready, g, !g);
            end
            if (g) begin
                push_write(1'b1, e_rd, e_data); exp_exu++;
            end else begin
                push_write(1'b1, lsu_rd, lsu_data); exp_lsu++;
            end
            tick();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL starve_queue empty cycle=%0d", i);
            end else begin
                e = exp_q.pop_front();
                if ({wen, waddr, wdata} !== e) begin
                    errors++;
                    $display("FAIL starve_port cycle=%0d got wen=%0b waddr=%0d wdata=%h expected wen=%0b waddr=%0d wdata=%h",
                             i, wen, waddr, wdata, e.wen, e.addr, e.data);
                end
            end
            if (g) begin
                e_rd = e_rd + 5'd1;
                e_data = e_data + 32'd1;
            end
        end
        exu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    task automatic test_rd0();
        lsu_valid = 1'b1; lsu_rd = '0; lsu_data = 32'hDEAD_BEEF; rs1_q = '0;
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL rd0_ready got lsu_ready=%0b rs1_busy=%0b expected 1 0", lsu_ready, rs1_busy);
        end
        push_write(1'b1, lsu_rd, lsu_data); exp_lsu++;
        tick();
        lsu_valid = 1'b0;
        checks++;
        e = exp_q.pop_front();
        if ({wen, waddr, wdata} !== e) begin
            errors++;
            $display("FAIL rd0_port got wen=%0b waddr=%0d wdata=%h expected wen=%0b waddr=%0d wdata=%h",
                     wen, waddr, wdata, e.wen, e.addr, e.data);
        end
    endtask

    task automatic test_scoreboard();
        rs1_q = 5'd5; rs2_q = 5'd6; sb_set = 1'b1; sb_set_rd = 5'd5;
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_pre_set got rs1_busy=%0b expected 0", rs1_busy);
        end
        tick();
        sb_set = 1'b0;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_set got rs1_busy=%0b rs2_busy=%0b expected 1 0", rs1_busy, rs2_busy);
        end
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hCAFE_0005;
        #1;
        push_write(1'b1, exu_rd, exu_data); exp_exu++;
        tick();
        exu_valid = 1'b0;
        #1;
        checks++;
        e = exp_q.pop_front();
        if ({wen, waddr, wdata} !== e || rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_inflight got wen=%0b waddr=%0d wdata=%h rs1_busy=%0b expected wen=%0b waddr=%0d wdata=%h rs1_busy=1",
                     wen, waddr, wdata, rs1_busy, e.wen, e.addr, e.data);
        end
        push_write(1'b0, '0, '0);
        tick();
        checks++;
        e = exp_q.pop_front();
        if (wen !== e.wen || rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_retired got wen=%0b rs1_busy=%0b expected wen=%0b rs1_busy=0", wen, rs1_busy, e.wen);
        end
    endtask

    task automatic test_same_cycle();
        sb_set = 1'b1; sb_set_rd = 5'd7;
        tick();
        sb_set_rd = 5'd9;
        tick();
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h7777_0007;
        sb_set_rd = 5'd7;
        #1;
        checks++;
        if (exu_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_rd_ready got exu_ready=%0b expected 1", exu_ready);
        end
        push_write(1'b1, exu_rd, exu_data); exp_exu++;
        tick();
        exu_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999_0009;
        sb_set_rd = 5'd11;
        checks++;
        e = exp_q.pop_front();
        if ({wen, waddr, wdata} !== e) begin
            errors++;
            $display("FAIL same_rd_port got wen=%0b waddr=%0d expected wen=%0b waddr=%0d", wen, waddr, e.wen, e.addr);
        end
        #1;
        push_write(1'b1, lsu_rd, lsu_data); exp_lsu++;
        tick();
        lsu_valid = 1'b0; sb_set = 1'b0;
        rs1_q = 5'd7; rs2_q = 5'd11;
        #1;
        checks++;
        e = exp_q.pop_front();
        if ({wen, waddr, wdata} !== e) begin
            errors++;
            $display("FAIL diff_rd_port got wen=%0b waddr=%0d expected wen=%0b waddr=%0d", wen, waddr, e.wen, e.addr);
        end
        checks++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
            errors++;
            $display("FAIL set_wins got rs7_busy=%0b rs11_busy=%0b expected 1 1", rs1_busy, rs2_busy);
        end
        push_write(1'b0, '0, '0);
        tick();
        e = exp_q.pop_front();
        rs2_q = 5'd9;
        #1;
        checks++;
        if (wen !== e.wen || rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL diff_rd_clear got wen=%0b rs7_busy=%0b rs9_busy=%0b expected wen=%0b 1 0",
                     wen, rs1_busy, rs2_busy, e.wen);
        end
`ifdef RF_WB_PERF_EN
        checks++;
        if (perf_exu_cnt !== 32'(exp_exu) || perf_lsu_cnt !== 32'(exp_lsu)) begin
            errors++;
            $display("FAIL perf_xfer got exu=%0d lsu=%0d expected exu=%0d lsu=%0d",
                     perf_exu_cnt, perf_lsu_cnt, exp_exu, exp_lsu);
        end
`endif
    endtask

    task automatic test_reset_mid();
        sb_set = 1'b1; sb_set_rd = 5'd2;
        tick();
        sb_set_rd = 5'd9;
        tick();
        sb_set = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd2; exu_data = 32'h2222_0002;
        push_write(1'b1, exu_rd, exu_data);
        tick();
        rs1_q = 5'd2; rs2_q = 5'd9;
        #1;
        checks++;
        e = exp_q.pop_front();
        if ({wen, waddr, wdata} !== e || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got wen=%0b waddr=%0d rs2_busy=%0b rs9_busy=%0b expected wen=1 waddr=2 1 1",
                     wen, waddr, rs1_busy, rs2_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({wen, waddr, wdata} !== '0 || exu_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_port got wen=%0b waddr=%0d wdata=%h exu_ready=%0b expected all 0",
                     wen, waddr, wdata, exu_ready);
        end
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_busy got rs1_busy=%0b rs2_busy=%0b expected 0 0", rs1_busy, rs2_busy);
        end
        rs1_q = 5'd7;
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_bit7 got rs1_busy=%0b expected 0", rs1_busy);
        end
`ifdef RF_WB_PERF_EN
        checks++;
        if ({perf_exu_cnt, perf_lsu_cnt, perf_stall_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset_perf got %0d %0d %0d expected 0 0 0", perf_exu_cnt, perf_lsu_cnt, perf_stall_cnt);
        end
`endif
        exp_q.delete();
        tick();
        exu_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_exu_only();
        test_starve();
        test_rd0();
        test_scoreboard();
        test_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
